// File: rtl/bank_stream_initiator.sv
// Strided burst initiator for the banked transpose SRAM: issues len reads or writes,
// collects read responses in a credit-protected FIFO and presents them on a valid/ready port.
module bank_stream_initiator #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 16,
   parameter int LEN_W      = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              cfg_we,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [ADDR_W-1:0] cfg_stride,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              req_v,
   output logic              req_we,
   output logic [ADDR_W-1:0] req_addr,
   output logic [DATA_W-1:0] req_wdata,
   input  logic              req_ready,
   input  logic              rsp_v,
   input  logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output logic              done,
   output logic              err
);
   // state | meaning
   // IDLE  | waiting for start, configuration latched on start
   // RUN   | issuing requests, one element per fire
   // DRAIN | read burst: all issued, waiting for FIFO to empty
   // FIN   | one-cycle done pulse
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

   state_t              state_q, state_nxt;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q, stride_q;
   logic [LEN_W-1:0]    rem_q;
   logic                inflight_q;
   logic                err_q;
   logic [DATA_W-1:0]   mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]    count_q, count_nxt;
   logic [CNT_W:0]      occ;
   logic                room, fire, last, push, pop, start_acc;

   assign start_acc = (state_q == S_IDLE) && start;
   assign fire      = req_v && req_ready;
   assign last      = (rem_q == LEN_W'(1));
   assign push      = rsp_v && inflight_q;
   assign pop       = out_valid && out_ready;
   // Credit check counts the read already in flight so the response always finds room.
   assign occ       = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
   assign room      = (occ < DEPTH_C);
   assign count_nxt = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_IDLE:  if (start) state_nxt = (cfg_len == '0) ? S_FIN : S_RUN;
         S_RUN:   if (fire && last) state_nxt = we_q ? S_FIN : S_DRAIN;
         S_DRAIN: if (!inflight_q && count_nxt == '0) state_nxt = S_FIN;
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      req_v     = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      wr_ready  = 1'b0;
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_FIN);
      if (state_q == S_RUN) req_v = we_q ? wr_valid : room;
      if (req_v) begin
         req_we    = we_q;
         req_addr  = addr_q;
         req_wdata = we_q ? wr_data : '0;
      end
      wr_ready = we_q && fire;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q       <= 1'b0;
         addr_q     <= '0;
         stride_q   <= '0;
         rem_q      <= '0;
         inflight_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         if (start_acc) begin
            we_q     <= cfg_we;
            addr_q   <= cfg_base;
            stride_q <= cfg_stride;
            rem_q    <= cfg_len;
         end else if (fire) begin
            addr_q <= addr_q + stride_q;
            rem_q  <= rem_q - LEN_W'(1);
         end
         inflight_q <= fire && !we_q;
         if (rsp_v && !inflight_q) err_q <= 1'b1;
         else if (start_acc)       err_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= rsp_rdata;
   end

   assign err       = err_q;
   assign out_valid = (count_q != '0);
   assign out_data  = out_valid ? mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_bank_stream_initiator.sv
// Self-checking bench for bank_stream_initiator with an SRAM model returning addr as data.
module tb_bank_stream_initiator;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 16;
   localparam int LEN_W  = 8;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              start = 1'b0, cfg_we = 1'b0;
   logic [ADDR_W-1:0] cfg_base = '0, cfg_stride = '0;
   logic [LEN_W-1:0]  cfg_len = '0;
   logic              wr_valid = 1'b0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              wr_ready, out_valid, out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic              req_v, req_we, req_ready = 1'b0;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_v, busy, done, err;
   logic [DATA_W-1:0] rsp_rdata;
   logic              sram_rsp, spur = 1'b0;
   logic [DATA_W-1:0] sram_data;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [DATA_W-1:0] exp_q[$];

   bank_stream_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_we(cfg_we), .cfg_base(cfg_base),
      .cfg_stride(cfg_stride), .cfg_len(cfg_len), .wr_valid(wr_valid), .wr_data(wr_data),
      .wr_ready(wr_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .req_v(req_v), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_v(rsp_v), .rsp_rdata(rsp_rdata), .busy(busy), .done(done),
      .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM: granted read at T answers with its address at T+1
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sram_rsp  <= 1'b0;
         sram_data <= '0;
      end else begin
         sram_rsp  <= req_v & req_ready & ~req_we;
         sram_data <= DATA_W'(req_addr);
      end
   end
   assign rsp_v     = sram_rsp | spur;
   assign rsp_rdata = sram_data;

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #3;
      checks++;
      if ({req_v, req_we, req_addr, req_wdata, wr_ready, out_valid, out_data, busy, done, err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {req_v, req_we, req_addr, req_wdata, wr_ready, out_valid, out_data, busy, done, err});
      end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_write_burst();
      logic [ADDR_W-1:0] a;
      @(negedge clk);
      start = 1; cfg_we = 1; cfg_base = 12'h010; cfg_stride = 12'h008; cfg_len = 4;
      wr_valid = 1; req_ready = 1;
      #1;
      checks++;
      if (req_v !== 1'b0) begin errors++; $display("FAIL wr_no_req_at_start: got %b expected 0", req_v); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         start = 0; wr_data = 16'hA000 + 16'(k);
         #1;
         a = 12'h010 + ADDR_W'(k * 8);
         checks++;
         if ({req_v, req_we, wr_ready, busy, done} !== 5'b11110) begin
            errors++; $display("FAIL wr_ctrl k=%0d: got %b expected 11110", k, {req_v, req_we, wr_ready, busy, done});
         end
         checks++;
         if (req_addr !== a) begin errors++; $display("FAIL wr_addr k=%0d: got %h expected %h", k, req_addr, a); end
         checks++;
         if (req_wdata !== 16'hA000 + 16'(k)) begin
            errors++; $display("FAIL wr_wdata k=%0d: got %h expected %h", k, req_wdata, 16'hA000 + 16'(k));
         end
      end
      @(negedge clk); #1;
      checks++;
      if ({done, busy, req_v} !== 3'b110) begin errors++; $display("FAIL wr_done: got %b expected 110", {done, busy, req_v}); end
      @(negedge clk); #1;
      checks++;
      if ({done, busy} !== 2'b00) begin errors++; $display("FAIL wr_idle: got %b expected 00", {done, busy}); end
      wr_valid = 0;
   endtask

   task automatic test_read_full();
      int nf = 0, np = 0, s, first_fire = -1, last_fire = -1, first_out = -1, last_pop = -1, done_cyc = -1;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] e;
      exp_q.delete();
      @(negedge clk);
      start = 1; cfg_we = 0; cfg_base = 12'h100; cfg_stride = 12'h003; cfg_len = 8;
      req_ready = 1; out_ready = 1;
      #1 s = cyc;
      for (int c = 0; c < 40 && done_cyc < 0; c++) begin
         @(negedge clk); start = 0; #1;
         if (req_v && req_ready) begin
            a = 12'h100 + ADDR_W'(nf * 3);
            checks++;
            if (req_addr !== a) begin errors++; $display("FAIL rd_addr n=%0d: got %h expected %h", nf, req_addr, a); end
            exp_q.push_back(DATA_W'(a));
            if (first_fire < 0) first_fire = cyc;
            last_fire = cyc; nf++;
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL rd_unexpected_data: got %h expected none", out_data); end
            else begin
               e = exp_q.pop_front();
               if (out_data !== e) begin errors++; $display("FAIL rd_data n=%0d: got %h expected %h", np, out_data, e); end
            end
            if (first_out < 0) first_out = cyc;
            last_pop = cyc; np++;
         end
         if (done) done_cyc = cyc;
      end
      checks++;
      if (first_fire != s + 1) begin errors++; $display("FAIL rd_first_fire: got %0d expected %0d", first_fire, s + 1); end
      checks++;
      if (nf != 8 || last_fire - first_fire != 7) begin
         errors++; $display("FAIL rd_full_rate: got %0d fires over %0d cycles expected 8 over 7", nf, last_fire - first_fire);
      end
      checks++;
      if (first_out - first_fire != 2) begin errors++; $display("FAIL rd_latency: got %0d expected 2", first_out - first_fire); end
      checks++;
      if (np != 8) begin errors++; $display("FAIL rd_pop_count: got %0d expected 8", np); end
      checks++;
      if (done_cyc != last_pop + 1) begin errors++; $display("FAIL rd_done_timing: got %0d expected %0d", done_cyc, last_pop + 1); end
   endtask

   task automatic test_read_backpressure();
      int nf = 0, np = 0, done_cyc = -1;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] e;
      exp_q.delete();
      @(negedge clk);
      start = 1; cfg_we = 0; cfg_base = 12'h200; cfg_stride = 12'h001; cfg_len = 8;
      req_ready = 1; out_ready = 0;
      #1;
      for (int c = 0; c < 70 && done_cyc < 0; c++) begin
         @(negedge clk); start = 0; out_ready = (c >= 10); #1;
         if (c == 9) begin
            checks++;
            if (nf != DEPTH || req_v !== 1'b0 || out_valid !== 1'b1) begin
               errors++; $display("FAIL bp_stall: got fires=%0d req_v=%b out_valid=%b expected 4 0 1", nf, req_v, out_valid);
            end
         end
         if (req_v && req_ready) begin
            a = 12'h200 + ADDR_W'(nf);
            checks++;
            if (req_addr !== a) begin errors++; $display("FAIL bp_addr n=%0d: got %h expected %h", nf, req_addr, a); end
            exp_q.push_back(DATA_W'(a));
            nf++;
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL bp_unexpected_data: got %h expected none", out_data); end
            else begin
               e = exp_q.pop_front();
               if (out_data !== e) begin errors++; $display("FAIL bp_data n=%0d: got %h expected %h", np, out_data, e); end
            end
            np++;
         end
         if (done) done_cyc = cyc;
      end
      checks++;
      if (np != 8 || nf != 8 || done_cyc < 0) begin
         errors++; $display("FAIL bp_complete: got fires=%0d pops=%0d done=%0d expected 8 8 seen", nf, np, done_cyc);
      end
      out_ready = 0;
   endtask

   task automatic test_arbiter_stall();
      int k = 0, seen_done = 0;
      logic [ADDR_W-1:0] a;
      @(negedge clk);
      start = 1; cfg_we = 1; cfg_base = 12'h030; cfg_stride = 12'h002; cfg_len = 3;
      wr_valid = 1; req_ready = 0;
      #1;
      for (int c = 0; c < 20 && seen_done == 0; c++) begin
         @(negedge clk);
         start = 0; req_ready = (c % 3 == 0); wr_data = 16'h5000 + 16'(k);
         #1;
         if (k == 3) begin
            checks++;
            if (done !== 1'b1 || req_v !== 1'b0) begin
               errors++; $display("FAIL stall_done: got done=%b req_v=%b expected 1 0", done, req_v);
            end
            seen_done = 1;
         end else begin
            a = 12'h030 + ADDR_W'(k * 2);
            checks++;
            if (req_v !== 1'b1 || req_addr !== a || req_wdata !== 16'h5000 + 16'(k)) begin
               errors++; $display("FAIL stall_req c=%0d: got v=%b addr=%h wd=%h expected 1 %h %h",
                                  c, req_v, req_addr, req_wdata, a, 16'h5000 + 16'(k));
            end
            checks++;
            if (wr_ready !== req_ready) begin
               errors++; $display("FAIL stall_wr_ready c=%0d: got %b expected %b", c, wr_ready, req_ready);
            end
            if (req_v && req_ready) k++;
         end
      end
      checks++;
      if (seen_done == 0) begin errors++; $display("FAIL stall_timeout: got %0d fires expected 3 then done", k); end
      wr_valid = 0; req_ready = 1;
      @(negedge clk);
   endtask

   task automatic test_len_zero_err();
      @(negedge clk);
      start = 1; cfg_we = 0; cfg_len = 0; #1;
      @(negedge clk); start = 0; #1;
      checks++;
      if ({done, busy, req_v} !== 3'b110) begin errors++; $display("FAIL len0_done: got %b expected 110", {done, busy, req_v}); end
      @(negedge clk); #1;
      checks++;
      if ({done, busy, req_v} !== 3'b000) begin errors++; $display("FAIL len0_idle: got %b expected 000", {done, busy, req_v}); end
      spur = 1;
      @(negedge clk); spur = 0; #1;
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", err); end
      @(negedge clk); #1;
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
      start = 1;
      @(negedge clk); start = 0; #1;
      checks++;
      if (err !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL err_clear: got err=%b done=%b expected 0 1", err, done); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_burst();
      int nf = 0, np = 0, done_cyc = -1;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] e;
      @(negedge clk);
      start = 1; cfg_we = 0; cfg_base = 12'h300; cfg_stride = 12'h001; cfg_len = 8;
      req_ready = 1; out_ready = 0;
      repeat (6) begin @(negedge clk); start = 0; end
      #1;
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL mid_prefill: got out_valid=%b busy=%b expected 1 1", out_valid, busy);
      end
      #2 rst_n = 0;
      #1;
      checks++;
      if ({req_v, req_we, req_addr, req_wdata, wr_ready, out_valid, out_data, busy, done, err} !== '0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got %h expected 0",
                  {req_v, req_we, req_addr, req_wdata, wr_ready, out_valid, out_data, busy, done, err});
      end
      @(negedge clk); @(negedge clk);
      rst_n = 1;
      exp_q.delete();
      @(negedge clk);
      start = 1; cfg_base = 12'hFFE; cfg_stride = 12'h001; cfg_len = 3; out_ready = 1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL post_reset_idle: got out_valid=%b busy=%b expected 0 0", out_valid, busy);
      end
      for (int c = 0; c < 30 && done_cyc < 0; c++) begin
         @(negedge clk); start = 0; #1;
         if (req_v && req_ready) begin
            a = 12'hFFE + ADDR_W'(nf);
            checks++;
            if (req_addr !== a) begin errors++; $display("FAIL wrap_addr n=%0d: got %h expected %h", nf, req_addr, a); end
            exp_q.push_back(DATA_W'(a));
            nf++;
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL post_unexpected_data: got %h expected none", out_data); end
            else begin
               e = exp_q.pop_front();
               if (out_data !== e) begin errors++; $display("FAIL post_data n=%0d: got %h expected %h", np, out_data, e); end
            end
            np++;
         end
         if (done) done_cyc = cyc;
      end
      checks++;
      if (nf != 3 || np != 3 || done_cyc < 0) begin
         errors++; $display("FAIL post_reset_burst: got fires=%0d pops=%0d done=%0d expected 3 3 seen", nf, np, done_cyc);
      end
   endtask

   initial begin
      test_reset();
      test_write_burst();
      test_read_full();
      test_read_backpressure();
      test_arbiter_stall();
      test_len_zero_err();
      test_reset_mid_burst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/bank_stream_initiator.md
# bank_stream_initiator

Single-stream initiator for the banked transpose SRAM: it drives one request port (valid/we/addr/wdata, same-cycle ready, fixed 1-cycle read response) with a strided burst of `len` reads or writes. Read responses land in a credit-protected FIFO and are presented on a valid/ready output. The SRAM response path cannot stall, so the block never issues a read without FIFO room. One instance per stream sits between the transpose sequencer and the banked SRAM.

## Interface
- ADDR_W, 12, request address width (low bits select the bank inside the SRAM)
- Data_W, 16, data width
- LEN_W, 8, burst length counter width
- FIFO_DEPTH, 4, read FIFO entries; must be a power of 2 and ≥2; full rate needs ≥3

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  launch burst; sampled only in IDLE
- cfg_we  in  1  1 = write burst, 0 = read burst (latched at start)
- cfg_base  in  ADDR_W  first address (latched)
- cfg_stride  in  ADDR_W  address increment per element (latched)
- cfg_len  in  LEN_W  element count; 0 allowed (latched)
- wr_valid  in  1  write data available
- wr_data  in  Data_W  write data
- wr_ready  out  1  write data consumed this cycle
- out_valid  out  1  read data available (FIFO head)
- out_data  out  Data_W  read data
- out_ready  in  1  downstream accepts read data
- req_v  out  1  request valid
- req_we  out  1  request write enable
- req_addr  out  ADDR_W  request address
- req_wdata  out  Data_W  request write data
- req_ready  in  1  same-cycle grant from the SRAM arbiter
- rsp_v  in  1  read response valid, exactly 1 cycle after a granted read
- rsp_rdata  in  Data_W  read response data
- busy  out  1  not IDLE
- done  out  1  1-cycle pulse at burst completion
- err  out  1  sticky: rsp_v received with no read in flight; cleared on accepted start

## Operation
- The FSM has four states: IDLE, RUN, DRAIN, FIN.
- IDLE: `start` latches the configuration. If cfg_len≠0 → RUN; otherwise → FIN. `start` in any other state is ignored.
- RUN issues request element `idx` at addr = base + idx·stride, computed incrementally and wrapping modulo 2^ADDR_W.
- Fire condition: fire = req_v & req_ready. On fire, idx and addr advance.
- req_v must never depend combinationally on req_ready. This avoids a loop through the arbiter.
- Write burst:
  - req_v = RUN & wr_valid.
  - req_wdata = wr_data.
  - wr_ready = fire.
  - On the last fire → FIN.
- Read burst:
  - req_v = RUN & (fifo_count + inflight < FIFO_DEPTH).
  - inflight is a register set by a read fire and cleared otherwise (at most 1).
  - On the last fire → DRAIN.
- Response handling:
  - rsp_v & inflight pushes rsp_rdata into the FIFO.
  - rsp_v & ~inflight sets err and discards the data.
- Output handshake: out_valid = fifo_count≠0. Pop on out_valid & out_ready. Push and pop can occur in the same cycle; count is unchanged.
- DRAIN: when inflight=0, fifo_count=0 and no push is pending → FIN.
- FIN: done=1 for one cycle, then → IDLE.
- req_we, req_addr and req_wdata are driven 0 whenever req_v=0.

## Timing
- Reset values:
  - All outputs are 0: req_v, req_we, req_addr, req_wdata, wr_ready, out_valid, out_data, busy, done, err.
  - FSM is in IDLE, FIFO is empty, inflight=0.
  - Reset mid-burst aborts immediately; no done pulse.
- Start and first request: start at cycle S → busy=1 and first req_v at S+1.
- Read latency: fire at T → rsp_v at T+1 → out_valid at T+2.
- Full rate: with req_ready=1, out_ready=1 and FIFO_DEPTH≥3, there is one fire per cycle. With FIFO_DEPTH=2, at least every other cycle.
- Back-pressure: with out_ready=0, issue stops once fifo_count+inflight reaches FIFO_DEPTH. No response is ever dropped.
- Write completion: last fire at T → done at T+1, busy=0 at T+2.
- Read completion: last pop at T → done at T+1.
- len=0: start at S → done at S+1, with no req_v.
- Address wrap: base=0xFFE, stride=1 → 0xFFE, 0xFFF, 0x000.

## Test plan
- Write burst, base=0x010, stride=8, len=4, wr_valid=1, req_ready=1 → req_addr 0x010, 0x018, 0x020, 0x028 on consecutive cycles with wr_ready each cycle; done 1 cycle after the 4th fire.
- Read burst, len=8, req_ready=1, out_ready=1, SRAM model returning addr as data → 8 consecutive fires; out_data equals the addresses in order; first out_valid 2 cycles after the first fire.
- Read burst, len=8, out_ready=0 for 10 cycles → exactly FIFO_DEPTH (4) fires then req_v=0. After out_ready=1, all 8 data arrive in order with no loss.
- Arbiter stall: req_ready toggling 1,0,0,1,… during a write burst → req_addr is held while ungranted; wr_ready only on grants; idx advances only on fire.
- len=0 start → done at S+1, no req_v. A spurious rsp_v in IDLE → err=1, cleared by the next start.
- Reset asserted mid read burst with data in the FIFO → all outputs 0 asynchronously. A new burst after reset behaves as from power-up.
